lsu_rmw: RTL and testbench

- Load/store unit directly upstream of the word-addressed data memory.
- Converts CPU byte/half/word load and store requests into word-wide memory accesses.
- Sub-word stores use a registered read-modify-write sequence; loads return sign- or zero-extended data one cycle after issue.
- Flags misaligned and out-of-range accesses; never writes memory on error.

---
 rtl/lsu_pkg.sv | 10 +
 rtl/lsu_rmw_if.sv | 29 ++
 rtl/lsu_lane.sv | 39 +++
 rtl/lsu_rmw.sv | 112 +++++++++++
 tb/tb_lsu_rmw.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit.
package lsu_pkg;
  localparam int DM_WORDS_DEF = 3072;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD_RSP, RMW_WR} state_t;
endpackage

// File: rtl/lsu_rmw_if.sv
// lsu_rmw_if: CPU request/response and data-memory signals of the LSU.
// slave = the LSU itself, master = CPU + memory side.
interface lsu_rmw_if;
  logic        req_valid;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        addr_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_we;
  logic [31:0] dm_pc;
  logic [31:0] dm_rdata;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, dm_rdata,
    output stall, rdata, rdata_valid, addr_err, dm_addr, dm_wdata, dm_we, dm_pc
  );
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_pc, dm_rdata,
    input  stall, rdata, rdata_valid, addr_err, dm_addr, dm_wdata, dm_we, dm_pc
  );
endinterface

// File: rtl/lsu_lane.sv
// lsu_lane: byte/half lane extraction with extension, and lane merge for stores.
// Word (and illegal) sizes pass the word / store data straight through.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] ld_val,
  output logic [31:0] st_word
);
  logic [4:0]  sh;
  logic [31:0] lane;

  // Select lane by shifting it down to bit 0, then extend or merge.
  always_comb begin
    sh      = 5'd0;
    lane    = word;
    ld_val  = word;
    st_word = wdata;
    case (size)
      SZ_BYTE: begin
        sh      = {addr, 3'b000};
        lane    = word >> sh;
        ld_val  = {{24{lane[7] & ~uns}}, lane[7:0]};
        st_word = (word & ~(32'h0000_00ff << sh)) | ({24'b0, wdata[7:0]} << sh);
      end
      SZ_HALF: begin
        sh      = {addr[1], 4'b0000};
        lane    = word >> sh;
        ld_val  = {{16{lane[15] & ~uns}}, lane[15:0]};
        st_word = (word & ~(32'h0000_ffff << sh)) | ({16'b0, wdata[15:0]} << sh);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of the word-addressed data memory.
// Word stores are single cycle; sub-word stores read, then write the merged
// word in RMW_WR; loads register the extended lane and report it in LOAD_RSP.
// Optional: define LSU_TRACE_EN to print memory writes and address errors.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  lsu_rmw_if.slave   bus
);
  state_t      state;
  logic [31:0] cap_word;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        addr_err_q;
  logic        err;
  logic        stall_c;
  logic        dm_we_c;
  logic [31:0] lane_word;
  logic [31:0] ld_val;
  logic [31:0] st_word;

  // Request legality: bad size, misalignment, or beyond the memory.
  always_comb begin
    err = (bus.req_size == 2'b11)
       || (bus.req_size == SZ_HALF && bus.req_addr[0])
       || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
       || (bus.req_addr >= 32'(4 * DM_WORDS));
  end

  // In RMW_WR merge into the captured word; otherwise work on live memory data.
  assign lane_word = (state == RMW_WR) ? cap_word : bus.dm_rdata;

  lsu_lane u_lane (
    .word    (lane_word),
    .addr    (bus.req_addr[1:0]),
    .size    (bus.req_size),
    .uns     (bus.req_unsigned),
    .wdata   (bus.req_wdata),
    .ld_val  (ld_val),
    .st_word (st_word)
  );

  // Same-cycle strobes: stall on multi-cycle ops, write on word store or RMW_WR.
  always_comb begin
    stall_c = 1'b0;
    dm_we_c = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: if (bus.req_valid && !err) begin
          if (bus.req_we && bus.req_size == SZ_WORD) dm_we_c = 1'b1;
          else                                       stall_c = 1'b1;
        end
        RMW_WR:  dm_we_c = 1'b1;
        default: ;
      endcase
    end
  end

  // FSM plus registered load result, valid and error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cap_word      <= '0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      addr_err_q    <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid) begin
          if (err) begin
            addr_err_q <= 1'b1;
          end else if (!bus.req_we) begin
            rdata_q       <= ld_val;
            rdata_valid_q <= 1'b1;
            state         <= LOAD_RSP;
          end else if (bus.req_size != SZ_WORD) begin
            cap_word <= bus.dm_rdata;
            state    <= RMW_WR;
          end
        end
        LOAD_RSP: state <= IDLE;
        RMW_WR:   state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  assign bus.stall       = stall_c;
  assign bus.dm_we       = dm_we_c;
  assign bus.dm_wdata    = st_word;
  assign bus.dm_addr     = {bus.req_addr[31:2], 2'b00};
  assign bus.dm_pc       = bus.req_pc;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.addr_err    = addr_err_q;

`ifdef LSU_TRACE_EN
  // Write and error trace.
  always @(posedge clk) begin
    if (!reset) begin
      if (dm_we_c) $display("@%h: *%h <= %h", bus.req_pc, bus.dm_addr, st_word);
      if (state == IDLE && bus.req_valid && err) $display("@%h: LSU addr_err %h", bus.req_pc, bus.req_addr);
    end
  end
`endif
endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: table-driven checks of lsu_rmw with a load-result scoreboard.
module tb_lsu_rmw;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_rmw_if bus();
  lsu_rmw #(.DM_WORDS(3072)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Memory model with backdoor preset port, single writer process.
  logic [31:0] mem [0:4095];
  logic        pre_en = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign bus.dm_rdata = mem[bus.dm_addr[13:2]];
  always @(posedge clk) begin
    if (bus.dm_we)   mem[bus.dm_addr[13:2]] <= bus.dm_wdata;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  typedef struct {
    logic        use_pre;
    logic [31:0] pre;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    int          exp_cyc;
    logic [31:0] exp_val;  // load result, or resulting memory word for stores
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preset(input logic [31:0] addr, input logic [31:0] val);
    pre_en = 1'b1; pre_idx = addr[13:2]; pre_val = val;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Scoreboard: every rdata_valid pulse must match the oldest pending load.
  always @(negedge clk) begin
    if (!reset && bus.rdata_valid) begin
      if (exp_q.size() == 0) chk("spurious_rdata_valid", 32'd1, 32'd0);
      else                   chk("rdata", bus.rdata, exp_q.pop_front());
    end
  end

  task automatic issue(input vec_t v, input logic [31:0] pc);
    int cyc;
    logic wrote, st;
    logic [11:0] idx;
    logic inrange;
    idx = v.addr[13:2];
    inrange = v.addr < 32'h3000;
    if (v.use_pre && inrange) preset(v.addr, v.pre);
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_size = v.sz;
    bus.req_unsigned = v.uns; bus.req_addr = v.addr; bus.req_wdata = v.wdata; bus.req_pc = pc;
    if (!v.we && !v.exp_err) exp_q.push_back(v.exp_val);
    cyc = 0; wrote = 1'b0;
    do begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("dm_addr", bus.dm_addr, {v.addr[31:2], 2'b00});
        chk("dm_pc", bus.dm_pc, pc);
      end
      cyc++;
      if (bus.dm_we) wrote = 1'b1;
      st = bus.stall;
      @(posedge clk); #1;
    end while (st && cyc < 8);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("addr_err", {31'b0, bus.addr_err}, {31'b0, v.exp_err});
    chk("cycles", cyc, v.exp_cyc);
    chk("dm_we_seen", {31'b0, wrote}, {31'b0, v.we & ~v.exp_err});
    if (v.we && !v.exp_err)                  chk("mem_word", mem[idx], v.exp_val);
    else if (v.we && inrange && v.use_pre)   chk("mem_kept", mem[idx], v.pre);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] spat;
    logic       we_seen;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    bus.req_valid = 0; bus.req_we = 0; bus.req_size = 0; bus.req_unsigned = 0;
    bus.req_addr = 0; bus.req_wdata = 0; bus.req_pc = 0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_dm_we", {31'b0, bus.dm_we}, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_rdata_valid", {31'b0, bus.rdata_valid}, 32'd0);
    chk("rst_addr_err", {31'b0, bus.addr_err}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    //            pre   preval        we  sz     uns  addr        wdata         err cyc exp
    vecs.push_back('{1'b0, 32'h0,        1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 0, 1, 32'hDEADBEEF}); // sw
    vecs.push_back('{1'b0, 32'h0,        0, 2'b10, 0, 32'h10,   32'h0,        0, 2, 32'hDEADBEEF}); // lw
    vecs.push_back('{1'b1, 32'h11223344, 1, 2'b00, 0, 32'h13,   32'h000000AB, 0, 2, 32'hAB223344}); // sb
    vecs.push_back('{1'b1, 32'h11223344, 1, 2'b01, 0, 32'h12,   32'h0000BEEF, 0, 2, 32'hBEEF3344}); // sh
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b00, 0, 32'h2,    32'h0,        0, 2, 32'hFFFFFFFF}); // lb
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b00, 1, 32'h2,    32'h0,        0, 2, 32'h000000FF}); // lbu
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b01, 0, 32'h2,    32'h0,        0, 2, 32'hFFFF80FF}); // lh
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b01, 1, 32'h0,    32'h0,        0, 2, 32'h00007F01}); // lhu
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b10, 1, 32'h0,    32'h0,        0, 2, 32'h80FF7F01}); // lw ignores uns
    vecs.push_back('{1'b1, 32'h80FF7F01, 0, 2'b00, 0, 32'h1,    32'h0,        0, 2, 32'h0000007F}); // lb positive
    vecs.push_back('{1'b1, 32'h12345678, 0, 2'b10, 0, 32'h2FFC, 32'h0,        0, 2, 32'h12345678}); // last word
    vecs.push_back('{1'b1, 32'h12345678, 1, 2'b00, 0, 32'h2FFF, 32'h000000C3, 0, 2, 32'hC3345678}); // last byte
    vecs.push_back('{1'b1, 32'h55667788, 0, 2'b10, 0, 32'h6,    32'h0,        1, 1, 32'h0});        // lw misaligned
    vecs.push_back('{1'b1, 32'h55667788, 1, 2'b01, 0, 32'h3,    32'h0000AAAA, 1, 1, 32'h0});        // sh misaligned
    vecs.push_back('{1'b0, 32'h0,        1, 2'b10, 0, 32'h3000, 32'hCAFEF00D, 1, 1, 32'h0});        // sw out of range
    vecs.push_back('{1'b1, 32'h55667788, 1, 2'b11, 0, 32'h8,    32'hFFFFFFFF, 1, 1, 32'h0});        // size 11 store
    vecs.push_back('{1'b1, 32'h55667788, 0, 2'b11, 0, 32'h8,    32'h0,        1, 1, 32'h0});        // size 11 load

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], 32'h1000 + 32'(i) * 4);

    // Reset in the RMW_WR cycle of a byte store
    preset(32'h4, 32'h11223344);
    issue('{1'b0, 32'h0, 0, 2'b10, 0, 32'h4, 32'h0, 0, 2, 32'h11223344}, 32'h2000);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b00; bus.req_unsigned = 0;
    bus.req_addr = 32'h4; bus.req_wdata = 32'h55; bus.req_pc = 32'h2004;
    @(negedge clk);
    chk("rmw_stall_first", {31'b0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_dm_we", {31'b0, bus.dm_we}, 32'd0);
    chk("rst_mid_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; bus.req_valid = 0;
    @(negedge clk);
    chk("rst_mid_rdata", bus.rdata, 32'd0);
    chk("rst_mid_valid", {31'b0, bus.rdata_valid}, 32'd0);
    chk("rst_mid_mem", mem[1], 32'h11223344);
    @(posedge clk); #1;
    issue('{1'b0, 32'h0, 0, 2'b10, 0, 32'h4, 32'h0, 0, 2, 32'h11223344}, 32'h2008);

    // Back-to-back: sb then lbu at the same address, no idle gap
    preset(32'h0, 32'h80FF7F01);
    bus.req_valid = 1; bus.req_we = 1; bus.req_size = 2'b00; bus.req_unsigned = 0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h5A; bus.req_pc = 32'h3000;
    @(negedge clk); spat[3] = bus.stall;
    @(posedge clk); #1;
    @(negedge clk); spat[2] = bus.stall; we_seen = bus.dm_we;
    @(posedge clk); #1;
    bus.req_we = 0; bus.req_unsigned = 1; bus.req_pc = 32'h3004;
    exp_q.push_back(32'h0000005A);
    @(negedge clk); spat[1] = bus.stall;
    @(posedge clk); #1;
    @(negedge clk); spat[0] = bus.stall;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk("b2b_stall_pattern", {28'b0, spat}, 32'hA);
    chk("b2b_rmw_we", {31'b0, we_seen}, 32'd1);
    chk("b2b_mem", mem[0], 32'h80FF7F5A);
    repeat (2) @(posedge clk);
    #1;
    chk("pending_loads", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: got hang expected finish");
    $fatal(1, "timeout");
  end
endmodule
